riscv_wb_arbiter: RTL

- Write-back scheduler in front of the 4-write-port integer register file.
- Collects write-back requests from NUM_REQ producers (ALU pipes, LSU, mul/div) over valid/ready.
- Grants up to 4 per cycle, round-robin, with pairwise-distinct non-zero destinations.
- Drives registered rd0..rd3 index/value pairs into the register file; idle ports are neutralised to x0/0.

---
 rtl/riscv_wb_pkg.sv | 24 ++
 rtl/riscv_wb_rr_select.sv | 74 +++++++
 rtl/riscv_wb_arbiter.sv | 135 +++++++++++++
 3 files changed

// File: rtl/riscv_wb_pkg.sv
// ---------------------------------------------------------------------------
// riscv_wb_pkg
// Shared constants and types for the write-back arbiter that feeds the
// 4-write-port integer register file.
//   REG_IDX_W : width of an architectural register index
//   XLEN      : integer data width
//   NUM_WR    : register-file write ports driven by the arbiter
//   REG_ZERO  : index of the hard-wired zero register
//   wb_req_t  : one write-back request (destination index + data)
// ---------------------------------------------------------------------------
package riscv_wb_pkg;

    localparam int REG_IDX_W = 5;
    localparam int XLEN      = 32;
    localparam int NUM_WR    = 4;

    localparam logic [REG_IDX_W-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [REG_IDX_W-1:0] rd;
        logic [XLEN-1:0]      value;
    } wb_req_t;

endpackage

// File: rtl/riscv_wb_rr_select.sv
// ---------------------------------------------------------------------------
// riscv_wb_rr_select
// Combinational round-robin grant logic for the write-back arbiter.
// Requesters are visited starting at i_ptr and wrapping modulo NUM_REQ.
// x0 writes are accepted and dropped, distinct non-zero destinations are
// packed onto the write ports in ascending order, and anything else stalls.
// Ports:
//   i_ptr        : round-robin start position
//   i_valid      : per-requester valid
//   i_rd         : per-requester destination index
//   o_ready      : per-requester accept
//   o_portIdx    : requester feeding each write port
//   o_portValid  : write port carries a real (non-x0) grant
//   o_anyGrant   : at least one non-x0 grant this cycle
//   o_lastIdx    : last requester granted a port, in scan order
// ---------------------------------------------------------------------------
module riscv_wb_rr_select
    import riscv_wb_pkg::*;
#(
    parameter int NUM_REQ = 6,
    parameter int PTR_W   = 3
) (
    input  logic [PTR_W-1:0]                     i_ptr,
    input  logic [NUM_REQ-1:0]                   i_valid,
    input  logic [NUM_REQ-1:0][REG_IDX_W-1:0]    i_rd,
    output logic [NUM_REQ-1:0]                   o_ready,
    output logic [NUM_WR-1:0][PTR_W-1:0]         o_portIdx,
    output logic [NUM_WR-1:0]                    o_portValid,
    output logic                                 o_anyGrant,
    output logic [PTR_W-1:0]                     o_lastIdx
);

    logic [PTR_W:0]          w_sum;
    logic [PTR_W-1:0]        w_idx;
    logic [2:0]              w_used;
    logic [(1<<REG_IDX_W)-1:0] w_taken;

    // Single scan in priority order. w_taken remembers destinations already
    // granted so a later requester with the same rd loses to the earlier one,
    // which keeps the write ports pairwise distinct.
    always_comb begin
        o_ready     = '0;
        o_portIdx   = '0;
        o_portValid = '0;
        o_anyGrant  = 1'b0;
        o_lastIdx   = '0;
        w_sum       = '0;
        w_idx       = '0;
        w_used      = 3'd0;
        w_taken     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            // The pointer is always below NUM_REQ, so one subtraction wraps it.
            w_sum = {1'b0, i_ptr} + (PTR_W+1)'(i);
            if (w_sum >= (PTR_W+1)'(NUM_REQ)) begin
                w_sum = w_sum - (PTR_W+1)'(NUM_REQ);
            end
            w_idx = w_sum[PTR_W-1:0];
            if (i_valid[w_idx]) begin
                if (i_rd[w_idx] == REG_ZERO) begin
                    o_ready[w_idx] = 1'b1;
                end else if (!w_taken[i_rd[w_idx]] && (w_used < 3'(NUM_WR))) begin
                    o_ready[w_idx]             = 1'b1;
                    o_portIdx[w_used[1:0]]     = w_idx;
                    o_portValid[w_used[1:0]]   = 1'b1;
                    w_taken[i_rd[w_idx]]       = 1'b1;
                    w_used                     = w_used + 3'd1;
                    o_anyGrant                 = 1'b1;
                    o_lastIdx                  = w_idx;
                end
            end
        end
    end

endmodule

// File: rtl/riscv_wb_arbiter.sv
// ---------------------------------------------------------------------------
// riscv_wb_arbiter
// Write-back scheduler in front of the 4-write-port integer register file.
// Accepts up to four write-backs per cycle from NUM_REQ producers and
// presents them, registered, on the rd0..rd3 write ports.
// Ports:
//   clk_i, rst_ni         : clock, asynchronous active-low reset
//   req_valid_i           : per-requester valid
//   req_rd_i              : packed destinations, requester k at [5k+4:5k]
//   req_value_i           : packed data, requester k at [32k+31:32k]
//   req_ready_o           : per-requester accept (combinational)
//   rdN_o / rdN_value_o   : registered regfile write ports (idle = x0/0)
//   pend_mask_o           : one-hot-per-register view of the current writes
//   conflict_cnt_o        : saturating count of cycles with a stalled requester
// ---------------------------------------------------------------------------
module riscv_wb_arbiter
    import riscv_wb_pkg::*;
#(
    parameter int NUM_REQ = 6,
    parameter int PTR_W   = 3
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [NUM_REQ*REG_IDX_W-1:0]  req_rd_i,
    input  logic [NUM_REQ*XLEN-1:0]       req_value_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    output logic [REG_IDX_W-1:0]          rd0_o,
    output logic [REG_IDX_W-1:0]          rd1_o,
    output logic [REG_IDX_W-1:0]          rd2_o,
    output logic [REG_IDX_W-1:0]          rd3_o,
    output logic [XLEN-1:0]               rd0_value_o,
    output logic [XLEN-1:0]               rd1_value_o,
    output logic [XLEN-1:0]               rd2_value_o,
    output logic [XLEN-1:0]               rd3_value_o,
    output logic [31:0]                   pend_mask_o,
    output logic [15:0]                   conflict_cnt_o
);

    wb_req_t                              w_req [NUM_REQ];
    logic [NUM_REQ-1:0]                   w_ready;
    logic [NUM_WR-1:0][PTR_W-1:0]         w_portIdx;
    logic [NUM_WR-1:0]                    w_portValid;
    logic                                 w_anyGrant;
    logic [PTR_W-1:0]                     w_lastIdx;
    logic [PTR_W-1:0]                     w_ptrNext;
    logic                                 w_stall;
    logic [NUM_WR-1:0][REG_IDX_W-1:0]     w_nextRd;
    logic [NUM_WR-1:0][XLEN-1:0]          w_nextVal;
    logic [31:0]                          w_nextPend;

    logic [PTR_W-1:0]                     r_rrPtr;
    logic [NUM_WR-1:0][REG_IDX_W-1:0]     r_rd;
    logic [NUM_WR-1:0][XLEN-1:0]          r_val;
    logic [31:0]                          r_pend;
    logic [15:0]                          r_cnt;

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
        assign w_req[k].rd    = req_rd_i[k*REG_IDX_W +: REG_IDX_W];
        assign w_req[k].value = req_value_i[k*XLEN +: XLEN];
    end

    riscv_wb_rr_select #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_select (
        .i_ptr       (r_rrPtr),
        .i_valid     (req_valid_i),
        .i_rd        (req_rd_i),
        .o_ready     (w_ready),
        .o_portIdx   (w_portIdx),
        .o_portValid (w_portValid),
        .o_anyGrant  (w_anyGrant),
        .o_lastIdx   (w_lastIdx)
    );

    // Nobody may hand over data while the block is held in reset.
    assign req_ready_o = w_ready & {NUM_REQ{rst_ni}};

    assign w_stall = |(req_valid_i & ~w_ready);

    assign w_ptrNext = (w_lastIdx == PTR_W'(NUM_REQ-1)) ? '0 : w_lastIdx + PTR_W'(1);

    // Route each granted requester onto its write port; idle ports stay x0/0.
    always_comb begin
        w_nextRd   = '0;
        w_nextVal  = '0;
        w_nextPend = '0;
        for (int p = 0; p < NUM_WR; p++) begin
            if (w_portValid[p]) begin
                for (int k = 0; k < NUM_REQ; k++) begin
                    if (w_portIdx[p] == PTR_W'(k)) begin
                        w_nextRd[p]  = w_req[k].rd;
                        w_nextVal[p] = w_req[k].value;
                    end
                end
                w_nextPend[w_nextRd[p]] = 1'b1;
            end
        end
    end

    // Output ports, pending mask, pointer and stall counter all move together.
    // The pointer only advances past real grants; x0 drops leave it alone.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rd    <= '0;
            r_val   <= '0;
            r_pend  <= '0;
            r_cnt   <= '0;
            r_rrPtr <= '0;
        end else begin
            r_rd   <= w_nextRd;
            r_val  <= w_nextVal;
            r_pend <= w_nextPend;
            if (w_anyGrant) begin
                r_rrPtr <= w_ptrNext;
            end
            if (w_stall && (r_cnt != 16'hFFFF)) begin
                r_cnt <= r_cnt + 16'd1;
            end
        end
    end

    assign rd0_o          = r_rd[0];
    assign rd1_o          = r_rd[1];
    assign rd2_o          = r_rd[2];
    assign rd3_o          = r_rd[3];
    assign rd0_value_o    = r_val[0];
    assign rd1_value_o    = r_val[1];
    assign rd2_value_o    = r_val[2];
    assign rd3_value_o    = r_val[3];
    assign pend_mask_o    = r_pend;
    assign conflict_cnt_o = r_cnt;

endmodule
